effect_compressor: RTL
======================

Name: effect_compressor

Overview:
- Per-sample dynamic-range compressor in the real-time effect chain, sitting directly downstream of the noise gate and upstream of tremolo/distortion.
- Consumes the gate's sample/valid pair and produces a compressed sample/valid pair on the same BCLK domain.
- Tracks a smoothed amplitude envelope, derives a 4:1 gain above a switch-selected threshold using a sequential divider, applies gain plus fixed makeup with saturation.
- Fixed latency, so downstream timing is identical whether the effect is enabled or bypassed.

Parameters:
ATK_SHIFT, 4, envelope attack smoothing shift (0 = instantaneous)
REL_SHIFT, 10, envelope release smoothing shift
MAKEUP_Q8, 256, makeup gain in unsigned Q8.8 (256 = 1.0), applied only when enabled

Ports:
i_clk  input  1  audio bit clock (BCLK); sole clock
i_rst_n  input  1  asynchronous active-low reset
i_valid  input  1  one-cycle strobe, new sample on i_data
i_enable  input  1  1 = compress, 0 = bypass (data passed unchanged, same latency)
i_level  input  3  threshold select
i_data  input  16  signed input sample
o_data  output  16  signed output sample, held between strobes
o_valid  output  1  one-cycle strobe, o_data updated
o_busy  output  1  high while a sample is in flight

Behaviour:
- Clocking and reset: one clock (i_clk); reset is asynchronous, active-low (i_rst_n).
- Reset values: o_data=0, o_valid=0, o_busy=0, envelope=0, FSM=IDLE, divider registers=0.
- FSM states are IDLE, ENV, DIV, APPLY.
  - IDLE: on i_valid, capture i_data, i_enable and i_level; go to ENV; o_busy=1 from the next cycle.
  - ENV (1 cycle):
    - a = |sample|, with -32768 mapping to 32767.
    - If a > env: env += (a-env)>>ATK_SHIFT; else env -= (env-a)>>REL_SHIFT.
    - env is 16-bit unsigned and never exceeds 32767.
    - Envelope updates whether or not the effect is enabled, so re-enabling causes no transient.
    - thr = 16384 >> level (level 0: 16384 ... level 7: 128).
    - If new env > thr: comp = thr + ((env-thr)>>2), divisor = env. Otherwise flag unity.
  - DIV (exactly 16 cycles):
    - Restoring radix-2 divide of (comp<<15)/env, one quotient bit per cycle, MSB first.
    - Quotient is 16-bit unsigned, gain in Q1.15, always <32768 on this path.
    - If unity is flagged, gain = 32768 and the divider result is ignored. The counter still runs the full 16 cycles.
  - APPLY (1 cycle):
    - If enabled: p = (sample*gain)>>>15 (arithmetic shift), then y = sat16((p*MAKEUP_Q8)>>>8), saturating to [-32768, 32767].
    - If disabled: y = sample.
    - Register o_data=y; return to IDLE.
- o_valid is high for exactly one cycle, the cycle after APPLY.
- Latency: i_valid sampled at edge N gives o_valid=1 during cycle N+19. This is fixed in all modes.
- o_busy is high from cycle N+1 through the APPLY cycle.
- i_valid while not IDLE is ignored: the sample is dropped, nothing is queued, and in-flight state is unaffected. Worst-case throughput is one sample per 19 cycles, well within one LRCK period.
- Changes to i_enable or i_level mid-flight have no effect on the in-flight sample; the values captured in IDLE are used.
- Reset asserted mid-operation: immediate return to reset values; the in-flight sample never produces o_valid.
- o_data holds its last value between strobes.

Test Plan:
- Reset, no stimulus -> o_data=0, o_valid=0, o_busy=0 for 100 cycles.
- i_enable=0, i_data=0x1234 strobe at cycle 0 -> o_valid only at cycle 19, o_data=0x1234, o_busy high cycles 1-18.
- ATK_SHIFT=0, i_enable=1, i_level=0:
  - i_data=32767 -> gain 20479, o_data=20478.
  - Next sample i_data=-32768 -> o_data=-20479.
- ATK_SHIFT=0, enabled, level 0, i_data=1000 (below threshold) -> o_data=1000. Same with MAKEUP_Q8=1024 and i_data=16000 -> o_data=32767 (saturated).
- Second i_valid at cycle 5 during DIV -> single o_valid at cycle 19 with the first sample's result; no second output.
- i_rst_n pulsed low at cycle 10 after a strobe -> no o_valid, o_busy=0, envelope=0, next strobe processed normally with 19-cycle latency.

Source files
------------

// File: rtl/effect_compressor.sv
// effect_compressor: per-sample 4:1 dynamic-range compressor with envelope
// follower, a sequential restoring divider for the gain, and fixed makeup gain
// with saturation. The latency is fixed whether the effect is enabled or
// bypassed.
//
// Ports:
//   i_clk    - audio bit clock (BCLK), the only clock
//   i_rst_n  - asynchronous active-low reset
//   i_valid  - one-cycle strobe; a new sample is on i_data
//   i_enable - 1 = compress, 0 = bypass (same latency)
//   i_level  - threshold select, threshold = 16384 >> level
//   i_data   - signed input sample
//   o_data   - signed output sample, held between strobes
//   o_valid  - one-cycle strobe; o_data has been updated
//   o_busy   - high while a sample is being processed
module effect_compressor #(
  parameter int unsigned ATK_SHIFT = 4,
  parameter int unsigned REL_SHIFT = 10,
  parameter int unsigned MAKEUP_Q8 = 256
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  input  logic               i_enable,
  input  logic [2:0]         i_level,
  input  logic signed [15:0] i_data,
  output logic signed [15:0] o_data,
  output logic               o_valid,
  output logic               o_busy
);

  localparam int unsigned DW       = 16;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned GAIN_W   = 18;
  localparam int unsigned PROD_W   = DW + GAIN_W;
  localparam int unsigned P_W      = PROD_W - 15;
  localparam int unsigned SCALED_W = P_W + GAIN_W;

  localparam logic signed [GAIN_W-1:0] MAKEUP_S = GAIN_W'(MAKEUP_Q8);
  localparam logic signed [GAIN_W-1:0] UNITY_G  = GAIN_W'(32768);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENV   = 2'd1,
    DIV   = 2'd2,
    APPLY = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic signed [DW-1:0]     sample_q, sample_d;
  logic                     enable_q, enable_d;
  logic [2:0]               level_q, level_d;
  logic [DW-1:0]            env_q, env_d;
  logic [DW-1:0]            rem_q, rem_d;
  logic [DW-1:0]            num_q, num_d;
  logic [DW-1:0]            quot_q, quot_d;
  logic [DW-1:0]            divisor_q, divisor_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     unity_q, unity_d;
  logic signed [DW-1:0]     data_q, data_d;
  logic                     valid_q, valid_d;
  logic                     busy_q, busy_d;

  // Datapath intermediates
  logic [DW-1:0]               abs_c;
  logic [DW-1:0]               env_new_c;
  logic [DW-1:0]               thr_c;
  logic [DW-1:0]               comp_c;
  logic [DW:0]                 trial_c;
  logic signed [GAIN_W-1:0]    gain_c;
  logic signed [PROD_W-1:0]    prod_c;
  logic signed [P_W-1:0]       p_c;
  logic signed [SCALED_W-1:0]  scaled_c;
  logic signed [SCALED_W-1:0]  shifted_c;
  logic signed [DW-1:0]        y_c;

  // Envelope follower, threshold and compressed target level
  always_comb begin
    if (sample_q[DW-1]) begin
      abs_c = (sample_q == DW'(16'h8000)) ? DW'(16'h7fff) : DW'(-sample_q);
    end else begin
      abs_c = DW'(sample_q);
    end
    if (abs_c > env_q) begin
      env_new_c = env_q + ((abs_c - env_q) >> ATK_SHIFT);
    end else begin
      env_new_c = env_q - ((env_q - abs_c) >> REL_SHIFT);
    end
    thr_c  = DW'(16'h4000) >> level_q;
    comp_c = thr_c + ((env_new_c - thr_c) >> 2);
  end

  // Gain application, makeup and saturation
  always_comb begin
    trial_c   = {rem_q, num_q[DW-1]};
    gain_c    = unity_q ? UNITY_G : $signed({2'b00, quot_q});
    prod_c    = PROD_W'(sample_q) * PROD_W'(gain_c);
    p_c       = P_W'(prod_c >>> 15);
    scaled_c  = SCALED_W'(p_c) * SCALED_W'(MAKEUP_S);
    shifted_c = scaled_c >>> 8;
    if (shifted_c > SCALED_W'(32767)) begin
      y_c = DW'(16'h7fff);
    end else if (shifted_c < -SCALED_W'(32768)) begin
      y_c = DW'(16'h8000);
    end else begin
      y_c = DW'(shifted_c);
    end
  end

  // Next-state and register-input logic
  always_comb begin
    state_d   = state_q;
    sample_d  = sample_q;
    enable_d  = enable_q;
    level_d   = level_q;
    env_d     = env_q;
    rem_d     = rem_q;
    num_d     = num_q;
    quot_d    = quot_q;
    divisor_d = divisor_q;
    cnt_d     = cnt_q;
    unity_d   = unity_q;
    data_d    = data_q;
    valid_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          sample_d = i_data;
          enable_d = i_enable;
          level_d  = i_level;
          state_d  = ENV;
        end
      end
      ENV: begin
        env_d     = env_new_c;
        unity_d   = !(env_new_c > thr_c);
        divisor_d = env_new_c;
        // Dividend is comp << 15: upper 16 bits seed the remainder,
        // lower 16 bits are shifted in one per step.
        rem_d     = comp_c >> 1;
        num_d     = {comp_c[0], 15'b0};
        quot_d    = '0;
        cnt_d     = '0;
        state_d   = DIV;
      end
      DIV: begin
        if (trial_c >= {1'b0, divisor_q}) begin
          rem_d  = DW'(trial_c - {1'b0, divisor_q});
          quot_d = {quot_q[DW-2:0], 1'b1};
        end else begin
          rem_d  = DW'(trial_c);
          quot_d = {quot_q[DW-2:0], 1'b0};
        end
        num_d = num_q << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(15)) begin
          state_d = APPLY;
        end
      end
      APPLY: begin
        data_d  = enable_q ? y_c : sample_q;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      sample_q  <= '0;
      enable_q  <= 1'b0;
      level_q   <= '0;
      env_q     <= '0;
      rem_q     <= '0;
      num_q     <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
      unity_q   <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sample_q  <= sample_d;
      enable_q  <= enable_d;
      level_q   <= level_d;
      env_q     <= env_d;
      rem_q     <= rem_d;
      num_q     <= num_d;
      quot_q    <= quot_d;
      divisor_q <= divisor_d;
      cnt_q     <= cnt_d;
      unity_q   <= unity_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_busy  = busy_q;

endmodule
